// File: rtl/pid_pwm_pkg.sv
// Shared widths, limits and types for the dual-channel PID PWM generator.
package pid_pwm_pkg;

  localparam int unsigned PRESCALE_W = 8;
  localparam int unsigned DUTY_W     = 8;
  localparam int unsigned CNT_MAX    = (2 ** DUTY_W) - 2;

  typedef logic [DUTY_W-1:0]     duty_t;
  typedef logic [PRESCALE_W-1:0] prescale_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

endpackage

// File: rtl/pid_pwm_gen_if.sv
// Control/observation bundle between the PID wrapper side and the PWM generator.
interface pid_pwm_gen_if;
  import pid_pwm_pkg::*;

  logic      en;
  prescale_t prescale;
  duty_t     duty0_in;
  duty_t     duty1_in;
  logic      pwm0_out;
  logic      pwm1_out;
  logic      period_start;
  duty_t     cnt_out;

  modport master (
    output en, prescale, duty0_in, duty1_in,
    input  pwm0_out, pwm1_out, period_start, cnt_out
  );

  modport slave (
    input  en, prescale, duty0_in, duty1_in,
    output pwm0_out, pwm1_out, period_start, cnt_out
  );

endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: period-aligned duty shadow plus registered compare output.
module pwm_channel
  import pid_pwm_pkg::*;
(
  input  logic  HCLK,
  input  logic  HRESETn,
  input  logic  en,
  input  logic  load,
  input  duty_t duty_in,
  input  duty_t cnt,
  output logic  pwm_out
);

  duty_t shadow;

  // Shadow follows duty_in while idle so re-enable starts from the live duty.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      shadow  <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (!en || load) begin
        shadow <= duty_in;
      end
      pwm_out <= en && (cnt < shadow);
    end
  end

endmodule

// File: rtl/pid_pwm_gen.sv
// Dual-channel PWM generator: prescaler, period counter and period_start framing.
module pid_pwm_gen
  import pid_pwm_pkg::*;
(
  input logic           HCLK,
  input logic           HRESETn,
  pid_pwm_gen_if.slave  bus
);

  run_state_e state_q, state_d;
  prescale_t  pre_cnt_q, pre_cnt_d;
  duty_t      cnt_q, cnt_d;
  logic       period_start_q, period_start_d;
  logic       tick_c;
  logic       wrap_c;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q        <= ST_IDLE;
      pre_cnt_q      <= '0;
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pre_cnt_q      <= pre_cnt_d;
      cnt_q          <= cnt_d;
      period_start_q <= period_start_d;
    end
  end

  // >= lets a lowered prescale take effect at once instead of waiting for a wrap.
  always_comb begin
    state_d        = state_q;
    pre_cnt_d      = '0;
    cnt_d          = '0;
    period_start_d = 1'b0;
    tick_c         = (pre_cnt_q >= bus.prescale);
    wrap_c         = tick_c && (cnt_q == DUTY_W'(CNT_MAX));

    if (!bus.en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d        = ST_RUN;
          period_start_d = 1'b1;
        end
        ST_RUN: begin
          period_start_d = wrap_c;
        end
      endcase

      pre_cnt_d = tick_c ? '0 : pre_cnt_q + PRESCALE_W'(1);

      if (tick_c) begin
        cnt_d = wrap_c ? '0 : cnt_q + DUTY_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  pwm_channel u_ch0 (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .en      (bus.en),
    .load    (wrap_c),
    .duty_in (bus.duty0_in),
    .cnt     (cnt_q),
    .pwm_out (bus.pwm0_out)
  );

  pwm_channel u_ch1 (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .en      (bus.en),
    .load    (wrap_c),
    .duty_in (bus.duty1_in),
    .cnt     (cnt_q),
    .pwm_out (bus.pwm1_out)
  );

  assign bus.cnt_out      = cnt_q;
  assign bus.period_start = period_start_q;

endmodule
